// File: rtl/oled_seq.sv
// SSD1306 OLED sequencer: streams the init command list and 1024-byte framebuffer
// pushes to a byte-oriented I2C master, one registered byte offer at a time.
module oled_seq #(
    parameter logic [6:0]  I2C_ADDR = 7'h3C,
    parameter int unsigned INIT_LEN = 25
) (
    input  logic       clk_32M,
    input  logic       rst,
    input  logic       start,
    input  logic       refresh,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_first,
    output logic       tx_last,
    input  logic       tx_ready,
    input  logic       tx_nack,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    output logic       busy,
    output logic       ready,
    output logic       err
);

    typedef enum logic [3:0] {
        StIdle, StIAddr, StICtrl, StICmd, StReady,
        StFAddr, StFCtrl, StFFetch, StFData, StErr
    } state_t;

    localparam logic [7:0] AddrByte = {I2C_ADDR, 1'b0};
    localparam logic [7:0] LastIdx  = 8'(INIT_LEN - 1);
    localparam logic [9:0] LastFb   = 10'd1023;

    state_t     state_q;
    logic [7:0] index_q;
    logic [7:0] data_q;
    logic       xfer;

    // Display off, clocking, mux, charge pump, horizontal addressing over the full
    // 128x64 window, segment/COM remap, contrast, display on.
    function automatic logic [7:0] rom(input logic [7:0] i);
        case (i)
            8'd0:  rom = 8'hAE;
            8'd1:  rom = 8'hD5;
            8'd2:  rom = 8'h80;
            8'd3:  rom = 8'hA8;
            8'd4:  rom = 8'h3F;
            8'd5:  rom = 8'h40;
            8'd6:  rom = 8'h8D;
            8'd7:  rom = 8'h14;
            8'd8:  rom = 8'h20;
            8'd9:  rom = 8'h00;
            8'd10: rom = 8'h21;
            8'd11: rom = 8'h00;
            8'd12: rom = 8'h7F;
            8'd13: rom = 8'h22;
            8'd14: rom = 8'h00;
            8'd15: rom = 8'h07;
            8'd16: rom = 8'hA1;
            8'd17: rom = 8'hC8;
            8'd18: rom = 8'hDA;
            8'd19: rom = 8'h12;
            8'd20: rom = 8'h81;
            8'd21: rom = 8'hCF;
            8'd22: rom = 8'hA4;
            8'd23: rom = 8'hA6;
            8'd24: rom = 8'hAF;
            default: rom = 8'hE3;
        endcase
    endfunction

    assign xfer  = tx_valid && tx_ready;
    assign busy  = !(state_q inside {StIdle, StReady, StErr});
    assign ready = (state_q == StReady);
    assign err   = (state_q == StErr);
    // Sync framebuffer RAM keeps re-reading the held fb_addr, so its output is stable
    // for the whole F_DATA offer, including stalls.
    assign tx_data = (state_q == StFData) ? fb_data : data_q;

    always_ff @(posedge clk_32M) begin
        if (rst) begin
            state_q  <= StIdle;
            tx_valid <= 1'b0;
            data_q   <= 8'h00;
            tx_first <= 1'b0;
            tx_last  <= 1'b0;
            fb_addr  <= 10'd0;
            index_q  <= 8'd0;
        end else if (busy && tx_nack) begin
            state_q  <= StErr;
            tx_valid <= 1'b0;
            tx_first <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StErr, StReady: begin
                    if (start || (state_q == StReady && refresh)) begin
                        state_q  <= start ? StIAddr : StFAddr;
                        tx_valid <= 1'b1;
                        data_q   <= AddrByte;
                        tx_first <= 1'b1;
                        tx_last  <= 1'b0;
                    end
                end
                StIAddr: if (xfer) begin
                    state_q  <= StICtrl;
                    data_q   <= 8'h00;
                    tx_first <= 1'b0;
                end
                StICtrl: if (xfer) begin
                    state_q <= StICmd;
                    index_q <= 8'd0;
                    data_q  <= rom(8'd0);
                    tx_last <= (LastIdx == 8'd0);
                end
                StICmd: if (xfer) begin
                    if (index_q == LastIdx) begin
                        state_q  <= StFAddr;
                        data_q   <= AddrByte;
                        tx_first <= 1'b1;
                        tx_last  <= 1'b0;
                    end else begin
                        index_q <= index_q + 8'd1;
                        data_q  <= rom(index_q + 8'd1);
                        tx_last <= ((index_q + 8'd1) == LastIdx);
                    end
                end
                StFAddr: if (xfer) begin
                    state_q  <= StFCtrl;
                    data_q   <= 8'h40;
                    tx_first <= 1'b0;
                    fb_addr  <= 10'd0;
                end
                StFCtrl: if (xfer) begin
                    state_q  <= StFFetch;
                    tx_valid <= 1'b0;
                end
                StFFetch: begin
                    state_q  <= StFData;
                    tx_valid <= 1'b1;
                    tx_last  <= (fb_addr == LastFb);
                end
                StFData: if (xfer) begin
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                    if (fb_addr == LastFb) begin
                        state_q <= StReady;
                    end else begin
                        state_q <= StFFetch;
                        fb_addr <= fb_addr + 10'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
